// File: rtl/led_bouncer_if.sv
// Control and display bundle of the LED bouncer: animation controls in,
// LED bar and hit counter out.
interface led_bouncer_if #(
  parameter int LED_W = 16
);
  logic             en;
  logic             speed;
  logic [LED_W-1:0] led;
  logic [7:0]       hit_cnt;

  modport master (output en, output speed, input led, input hit_cnt);
  modport slave  (input en, input speed, output led, output hit_cnt);
endinterface

// File: rtl/led_bouncer.sv
// Two bouncing single-LED walkers plus a bouncing multi-LED block on an LED bar.
// Optional macro LED_BOUNCER_WRAP_EN makes walkers wrap around the bar ends.
module led_bouncer #(
  parameter int LED_W    = 16,
  parameter int DIV_W    = 23,
  parameter int RATIO    = 4,
  parameter int BLK_W    = 3,
  parameter int BLK_LO   = 5,
  parameter int BLK_HI   = 11,
  parameter int BLK_INIT = 9
) (
  input logic         clk,
  input logic         rst,
  led_bouncer_if.slave bus
);

  localparam int POS_W   = $clog2(LED_W);
  localparam int RW      = $clog2(RATIO);
  localparam int A_MAX   = LED_W - 1;
  localparam int BLK_TOP = BLK_HI - BLK_W + 1;

  localparam logic [LED_W-1:0] BLK_ONES = LED_W'((1 << BLK_W) - 1);
  localparam logic [LED_W-1:0] LED_RST  = (LED_W'(1) << (LED_W - 1)) | LED_W'(1)
                                        | (BLK_ONES << BLK_INIT);

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic [RW-1:0]    ratio_q, ratio_d;
  logic [POS_W-1:0] a_q, a_d, b_q, b_d, blk_q, blk_d;
  dir_e             a_dir_q, a_dir_d, b_dir_q, b_dir_d, blk_dir_q, blk_dir_d;
  logic [7:0]       hit_q, hit_d;
  logic [LED_W-1:0] led_q, led_d;

  logic tick, step, slow, walk_mv, blk_mv;
  logic blk_bad, a_out, a_blk, a_walk, b_out, b_blk, b_walk;
  logic a_hit, b_hit;
  logic [8:0] hit_sum;
  int blk_c, blk_new, a_c, b_c;

  function automatic logic on_block(input int w, input int lo);
    return (w >= lo) && (w <= lo + BLK_W - 1);
  endfunction

  always_comb begin
    div_d     = div_q + DIV_W'(1);
    ratio_d   = ratio_q;
    a_d       = a_q;
    b_d       = b_q;
    blk_d     = blk_q;
    a_dir_d   = a_dir_q;
    b_dir_d   = b_dir_q;
    blk_dir_d = blk_dir_q;
    a_walk    = 1'b0;
    b_walk    = 1'b0;

    tick    = &div_q;
    step    = tick && bus.en;
    slow    = step && (ratio_q == '0);
    walk_mv = bus.speed ? slow : step;
    blk_mv  = bus.speed ? step : slow;
    if (step) ratio_d = ratio_q + RW'(1);

    // Block resolves first against the walkers' current bits.
    blk_c   = int'(blk_q) + ((blk_dir_q == DIR_UP) ? 1 : -1);
    blk_bad = (blk_c < BLK_LO) || (blk_c > BLK_TOP)
           || on_block(int'(a_q), blk_c) || on_block(int'(b_q), blk_c);
    if (blk_mv) begin
      if (blk_bad) blk_dir_d = (blk_dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
      else         blk_d     = POS_W'(blk_c);
    end
    blk_new = int'(blk_d);

    a_c = int'(a_q) + ((a_dir_q == DIR_UP) ? 1 : -1);
    b_c = int'(b_q) + ((b_dir_q == DIR_UP) ? 1 : -1);
`ifdef LED_BOUNCER_WRAP_EN
    if (a_c > A_MAX) a_c = 0;
    else if (a_c < 0) a_c = A_MAX;
    if (b_c > A_MAX) b_c = 0;
    else if (b_c < 0) b_c = A_MAX;
    a_out = 1'b0;
    b_out = 1'b0;
`else
    a_out = (a_c < 0) || (a_c > A_MAX);
    b_out = (b_c < 0) || (b_c > A_MAX);
`endif
    a_blk = on_block(a_c, blk_new);
    b_blk = on_block(b_c, blk_new);

    // A settles before B so the two walkers can never land on one bit.
`ifdef LED_BOUNCER_WRAP_EN
    a_walk = (a_c == int'(b_q));
`endif
    if (walk_mv) begin
      if (a_out || a_blk || a_walk) a_dir_d = (a_dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
      else                          a_d     = POS_W'(a_c);
    end
`ifdef LED_BOUNCER_WRAP_EN
    b_walk = (b_c == int'(a_d));
`endif
    if (walk_mv) begin
      if (b_out || b_blk || b_walk) b_dir_d = (b_dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
      else                          b_d     = POS_W'(b_c);
    end

    a_hit   = walk_mv && a_blk;
    b_hit   = walk_mv && b_blk;
    hit_sum = 9'(hit_q) + 9'(a_hit) + 9'(b_hit);
    hit_d   = hit_sum[8] ? 8'hFF : hit_sum[7:0];

    led_d = (LED_W'(1) << a_d) | (LED_W'(1) << b_d) | (BLK_ONES << blk_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      ratio_q   <= '0;
      a_q       <= POS_W'(LED_W - 1);
      a_dir_q   <= DIR_DOWN;
      b_q       <= '0;
      b_dir_q   <= DIR_UP;
      blk_q     <= POS_W'(BLK_INIT);
      blk_dir_q <= DIR_DOWN;
      hit_q     <= '0;
      led_q     <= LED_RST;
    end else begin
      div_q     <= div_d;
      ratio_q   <= ratio_d;
      a_q       <= a_d;
      a_dir_q   <= a_dir_d;
      b_q       <= b_d;
      b_dir_q   <= b_dir_d;
      blk_q     <= blk_d;
      blk_dir_q <= blk_dir_d;
      hit_q     <= hit_d;
      led_q     <= led_d;
    end
  end

  assign bus.led     = led_q;
  assign bus.hit_cnt = hit_q;

endmodule
